// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: row drive, 2-FF column synchroniser,
// lowest-code frame candidate, frame-count debounce, and a one-cycle press pulse.
module keypad_scan #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [4:0] key,
  output logic [4:0] key_pulse
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_MAX   = 4'(DEBOUNCE_SCANS);

  logic [3:0]  col_meta;
  logic [3:0]  col_sync;
  logic [15:0] div;
  logic [1:0]  row;
  logic [4:0]  acc;
  logic [4:0]  last_cand;
  logic [3:0]  stable_cnt;

  logic        sample;
  logic        frame_end;
  logic [4:0]  row_hit;
  logic [4:0]  cand;
  logic [4:0]  last_next;
  logic [3:0]  cnt_next;
  logic        commit;

  assign key_row   = ~(4'b0001 << row);
  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (row == 2'd3);

  // Scanning columns downward leaves the lowest pressed column in row_hit.
  always_comb begin
    row_hit = 5'h00;
    for (int c = 3; c >= 0; c--) begin
      if (!col_sync[c]) row_hit = {1'b1, row, 2'(c)};
    end
  end

  // Earlier rows hold lower codes, so an existing hit always wins.
  assign cand = acc[4] ? acc : row_hit;

  always_comb begin
    last_next = last_cand;
    cnt_next  = stable_cnt;
    if (cand == last_cand) begin
      cnt_next = (stable_cnt >= DB_MAX) ? DB_MAX : stable_cnt + 4'd1;
    end else begin
      last_next = cand;
      cnt_next  = 4'd1;
    end
  end

  assign commit = frame_end && (cnt_next == DB_MAX) && (last_next != key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= key_col;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= 16'd0;
      row <= 2'd0;
    end else if (sample) begin
      div <= 16'd0;
      row <= row + 2'd1;
    end else begin
      div <= div + 16'd1;
    end
  end

  // The frame-end edge both consumes the candidate and clears the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= 5'h00;
      last_cand  <= 5'h00;
      stable_cnt <= 4'd0;
    end else if (frame_end) begin
      acc        <= 5'h00;
      last_cand  <= last_next;
      stable_cnt <= cnt_next;
    end else if (sample) begin
      acc <= cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key       <= 5'h00;
      key_pulse <= 5'h00;
    end else begin
      key_pulse <= 5'h00;
      if (commit) begin
        key <= last_next;
        if (last_next[4]) key_pulse <= last_next;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 matrix model;
// SCAN_DIV = 4 and DEBOUNCE_SCANS = 3, so one frame is 16 cycles.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [4:0]  key;
  logic [4:0]  key_pulse;
  logic [15:0] keys = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  logic [4:0] last_pulse = 5'h00;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .key_col(key_col),
    .key_row(key_row), .key(key), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row to its column; pull-ups otherwise.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && keys[r*4+c]) key_col[c] = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    if (!rst && key_pulse != 5'h00) begin
      pulse_cnt++;
      last_pulse = key_pulse;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic frames(input int n);
    repeat (16 * n) tick();
  endtask

  task automatic to_frame_start();
    while (cyc % 16 != 0) tick();
  endtask

  // Expects key to move old_v -> new_v on the edge closing the n-th frame from now.
  task automatic expect_commit(input string tag, input int n, input logic [4:0] old_v,
                               input logic [4:0] new_v, input logic [4:0] pulse_v);
    repeat (16 * n - 1) tick();
    check({tag, "_key_before"}, 8'(key), 8'(old_v));
    tick();
    check({tag, "_key_after"}, 8'(key), 8'(new_v));
    check({tag, "_pulse"}, 8'(key_pulse), 8'(pulse_v));
    tick();
    check({tag, "_pulse_clear"}, 8'(key_pulse), 8'h00);
    to_frame_start();
  endtask

  initial begin
    int pc0;
    logic [3:0] row_exp;

    // 1: reset values and row scan
    repeat (3) @(negedge clk);
    check("rst_row", 8'(key_row), 8'h0E);
    check("rst_key", 8'(key), 8'h00);
    check("rst_pulse", 8'(key_pulse), 8'h00);
    rst = 1'b0;
    cyc = 0;
    for (int n = 0; n < 16; n++) begin
      row_exp = ~(4'b0001 << (n / 4));
      check("scan_row", 8'(key_row), 8'(row_exp));
      check("scan_key", 8'(key), 8'h00);
      check("scan_pulse", 8'(key_pulse), 8'h00);
      tick();
    end

    // 2: single press of key 1
    keys = 16'h0002;
    pc0 = pulse_cnt;
    expect_commit("press1", 3, 5'h00, 5'h11, 5'h11);
    frames(3);
    check("press1_hold", 8'(key), 8'h11);
    check("press1_npulse", 8'(pulse_cnt - pc0), 8'd1);

    // 3: release
    keys = 16'h0000;
    pc0 = pulse_cnt;
    expect_commit("release1", 3, 5'h11, 5'h00, 5'h00);
    check("release1_npulse", 8'(pulse_cnt - pc0), 8'd0);

    // 4: bounce on key 3 in alternate frames
    pc0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      frames(1);
    end
    check("bounce_key", 8'(key), 8'h00);
    check("bounce_npulse", 8'(pulse_cnt - pc0), 8'd0);
    keys = 16'h0008;
    expect_commit("press3", 3, 5'h00, 5'h13, 5'h13);

    // 5: keys 6 and 9 together, then release 6
    keys = 16'h0240;
    pc0 = pulse_cnt;
    expect_commit("multi", 3, 5'h13, 5'h16, 5'h16);
    keys = 16'h0200;
    expect_commit("change", 3, 5'h16, 5'h19, 5'h19);
    check("change_npulse", 8'(pulse_cnt - pc0), 8'd2);
    check("change_lastpulse", 8'(last_pulse), 8'h19);

    // 6: reset during frame 2 of a key 5 press
    keys = 16'h0020;
    frames(1);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_key", 8'(key), 8'h00);
    check("midrst_pulse", 8'(key_pulse), 8'h00);
    check("midrst_row", 8'(key_row), 8'h0E);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    pc0 = pulse_cnt;
    check("midrst_release_pulse", 8'(key_pulse), 8'h00);
    expect_commit("press5", 3, 5'h00, 5'h15, 5'h15);
    check("press5_npulse", 8'(pulse_cnt - pc0), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad, synchronises and debounces the column returns, and produces the 5-bit `key` level and `key_pulse` event codes consumed by the game graphics/control stage. It sits between the board keypad pins and the graphics module. Both outputs are encoded as {valid, code[3:0]}, so 5'h11 means key 1 is pressed and 5'h13 means key 3 is pressed.

## Interface
- `SCAN_DIV`, default 25000: number of clk cycles each row is driven. Legal range is 4..65535.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-frame results needed to commit a change. Legal range is 1..15.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `key_col`  in  4  keypad column returns; active-low; external pull-ups.
- `key_row`  out  4  row drive; one-hot active-low.
- `key`  out  5  debounced key level: {pressed, code}, or 5'h00 when no key is pressed.
- `key_pulse`  out  5  equals the new `key` value for exactly one cycle when a new press is committed, otherwise 5'h00.

## Operation
- **Column synchroniser:** `key_col` passes through a 2-FF synchroniser before any use.
- **Row scan:**
  - A divider counts 0..SCAN_DIV-1 and then wraps.
  - The row index 0..3 advances when the divider wraps. Row 3 wraps to row 0.
  - `key_row` = ~(4'b0001 << row).
  - One frame is 4*SCAN_DIV cycles.
- **Sampling:**
  - Synchronised columns are sampled in the cycle where div == SCAN_DIV-1, at the end of the row period, so they have settled.
  - A column bit at 0 means key code = row*4 + col is pressed.
- **Frame candidate:**
  - The candidate is the lowest pressed code found in the frame, compared in row-major order. Any multi-key press therefore resolves to the lowest code.
  - If nothing is pressed, the candidate is "none".
  - The frame accumulator clears at the start of each frame.
  - The candidate is formed at the row-3 sample edge and includes the row-3 columns from that same sample.
- **Debounce:**
  - Two registers are kept: `last_cand` and `stable_cnt`.
  - At each frame end, if the candidate equals `last_cand`, `stable_cnt` increments and saturates at DEBOUNCE_SCANS.
  - Otherwise `last_cand` <= candidate and `stable_cnt` <= 1.
- **Commit:**
  - Commit happens at the frame-end edge where the updated `stable_cnt` equals DEBOUNCE_SCANS and `last_cand` differs from the committed value.
  - Pressed code c: `key` <= {1'b1, c}.
  - "None": `key` <= 5'h00.
- **Pulse:**
  - `key_pulse` is registered.
  - It is {1'b1, c} for one cycle exactly when a commit moves `key` to a pressed value. This covers both release-to-press and a direct change from code A to code B.
  - Release commits produce no pulse.
  - A held key produces a single pulse and does not repeat.

## Timing
- **Reset state:** divider = 0, row = 0, `key_row` = 4'b1110, synchroniser = 4'b1111, accumulator = none, `last_cand` = none, `stable_cnt` = 0, `key` = 5'h00, `key_pulse` = 5'h00.
- **Reset mid-operation:** all of the above take effect immediately on `rst` assertion. No pulse is generated on reset release.
- **Commit latency:** for a press stable from the start of frame k, `key` and `key_pulse` change together at the edge closing frame k+DEBOUNCE_SCANS-1.
- **Release latency:** release follows the same DEBOUNCE_SCANS-frame rule.
- **Pulse width:** `key_pulse` returns to 5'h00 on the very next cycle.
- **Glitch rejection:** a bounce shorter than one frame that changes only a single frame's candidate restarts `stable_cnt`. It never commits.
- **DEBOUNCE_SCANS = 1:** commits on the first differing frame.
- **Row change to sample:** there is at least SCAN_DIV-1 ≥ 3 cycles between a row change and its sample, which covers the 2-FF delay plus one cycle of settling.
- **Simultaneous events:** a commit and the next frame's accumulator clear on the same edge do not interfere.

## Test plan
Bench parameters: SCAN_DIV = 4, DEBOUNCE_SCANS = 3, so one frame is 16 cycles.
1. **Reset values and row scan:**
   - Stimulus: reset, then run with all columns 4'hF.
   - Required: `key_row` sequences 1110, 1101, 1011, 0111 with each value held 4 cycles; `key` = `key_pulse` = 5'h00 throughout.
2. **Single press:**
   - Stimulus: model key 1 (row 0, col 1) held from a frame start.
   - Required: after 3 frames, `key` = 5'h11 and `key_pulse` = 5'h11 for exactly 1 cycle then 5'h00; `key` holds 5'h11 with no further pulses.
3. **Release:**
   - Stimulus: release key 1.
   - Required: `key` = 5'h00 after 3 frames; no pulse.
4. **Bounce rejection:**
   - Stimulus: toggle key 3 in alternate frames for 10 frames.
   - Required: `key` stays 5'h00 and no pulse occurs. Then hold key 3 for 3 frames; required: `key` = `key_pulse` = 5'h13.
5. **Multi-key priority and code change:**
   - Stimulus: hold keys 6 and 9 together.
   - Required: `key` = 5'h16. Then release key 6 only; required: after 3 frames, `key` = 5'h19 with a single pulse of 5'h19.
6. **Reset mid-debounce:**
   - Stimulus: assert `rst` during frame 2 of a key 5 press, then release `rst` with key 5 still held.
   - Required: outputs go to 0 immediately; `key` = 5'h15 exactly 3 full frames after reset release.
